// File: rtl/accel_bcd_sched_pkg.sv
// Shared definitions for the accelerometer BCD scheduler: default sizes,
// axis indices, FSM state encoding and the axis-selection helper.
package accel_bcd_sched_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DIGITS_DEF = 5;

    localparam logic [1:0] AX_X    = 2'd0;
    localparam logic [1:0] AX_Y    = 2'd1;
    localparam logic [1:0] AX_Z    = 2'd2;
    localparam logic [1:0] AX_NONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Lowest enabled axis with index >= lo, or AX_NONE when there is none.
    function automatic logic [1:0] first_axis(input logic [2:0] mask, input logic [1:0] lo);
        logic [1:0] r;
        r = AX_NONE;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/accel_bcd_sched_dabble.sv
// Iterative binary-to-BCD converter (shift-add-3). A start pulse loads the
// operand; one bit is consumed per cycle and valid pulses once the last bit
// has been shifted in, exactly DATA_W cycles after the load edge.
module accel_bcd_sched_dabble
    import accel_bcd_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;

    // Add 3 to every digit that is 5 or more before the next left shift.
    always_comb begin
        adj_d = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj_d[4*d +: 4] >= 4'd5) begin
                adj_d[4*d +: 4] = adj_d[4*d +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(DATA_W);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            bcd_q   <= {adj_d[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_q   <= {bin_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
            valid_q <= (cnt_q == CNT_W'(1));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bcd_o   = bcd_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/accel_bcd_sched.sv
// Time-multiplexes one BCD converter over the X/Y/Z accelerometer axes and
// publishes all three magnitudes and signs together with a done pulse.
//
//  state | meaning
//  IDLE  | waiting for a sample strobe
//  LOAD  | take |sample| of the current axis, start the converter
//  CONV  | converter running, DATA_W cycles
//  STORE | write digits and sign into the axis shadow register
//  DONE  | done pulse; shadow copied to outputs on the exiting edge
module accel_bcd_sched
    import accel_bcd_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_W-1:0]     data_x_i,
    input  logic [DATA_W-1:0]     data_y_i,
    input  logic [DATA_W-1:0]     data_z_i,
    input  logic [2:0]            axis_mask_i,
    input  logic                  clr_ovr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o,
    output logic [4*DIGITS-1:0]   bcd_x_o,
    output logic [4*DIGITS-1:0]   bcd_y_o,
    output logic [4*DIGITS-1:0]   bcd_z_o,
    output logic                  neg_x_o,
    output logic                  neg_y_o,
    output logic                  neg_z_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W);

    state_t                     state_q;
    logic [DATA_W-1:0]          wx_q, wy_q, wz_q;
    logic [2:0]                 wmask_q;
    logic [DATA_W-1:0]          px_q, py_q, pz_q;
    logic [2:0]                 pmask_q;
    logic                       pend_q;
    logic [1:0]                 ax_q;
    logic                       cur_neg_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [2:0][BCD_W-1:0]      sh_bcd_q;
    logic [2:0]                 sh_neg_q;
    logic [2:0][BCD_W-1:0]      out_bcd_q;
    logic [2:0]                 out_neg_q;
    logic                       done_q;
    logic                       ovr_q;

    logic                       job_go_d;
    logic [DATA_W-1:0]          job_x_d, job_y_d, job_z_d;
    logic [2:0]                 job_mask_d;
    logic [1:0]                 job_first_d;
    logic [1:0]                 next_ax_d;
    logic [DATA_W-1:0]          sel_d;
    logic                       sel_neg_d;
    logic [DATA_W-1:0]          mag_d;
    logic                       set_ovr_d;
    logic [BCD_W-1:0]           dab_bcd;
    logic                       dab_valid;

    // Pick the job that starts on this edge: a fresh strobe beats the pending buffer.
    always_comb begin
        job_go_d   = 1'b0;
        job_x_d    = data_x_i;
        job_y_d    = data_y_i;
        job_z_d    = data_z_i;
        job_mask_d = axis_mask_i;
        if (state_q == ST_IDLE) begin
            job_go_d = sample_valid_i;
        end else if (state_q == ST_DONE) begin
            if (sample_valid_i) begin
                job_go_d = 1'b1;
            end else if (pend_q) begin
                job_go_d   = 1'b1;
                job_x_d    = px_q;
                job_y_d    = py_q;
                job_z_d    = pz_q;
                job_mask_d = pmask_q;
            end
        end
    end

    assign job_first_d = first_axis(job_mask_d, AX_X);
    assign next_ax_d   = first_axis(wmask_q, ax_q + 2'd1);

    // Axis mux and magnitude; the most negative value maps to 2**(DATA_W-1) unsigned.
    always_comb begin
        case (ax_q)
            AX_X:    sel_d = wx_q;
            AX_Y:    sel_d = wy_q;
            default: sel_d = wz_q;
        endcase
        sel_neg_d = sel_d[DATA_W-1];
        mag_d     = sel_neg_d ? -sel_d : sel_d;
    end

    // Any strobe arriving while busy with a full pending slot loses a sample.
    assign set_ovr_d = sample_valid_i && (state_q != ST_IDLE) && pend_q;

    accel_bcd_sched_dabble #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (state_q == ST_LOAD),
        .bin_i   (mag_d),
        .bcd_o   (dab_bcd),
        .valid_o (dab_valid)
    );

    // Sequencer, pending buffer, shadow and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wx_q      <= '0;
            wy_q      <= '0;
            wz_q      <= '0;
            wmask_q   <= '0;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
            pmask_q   <= '0;
            pend_q    <= 1'b0;
            ax_q      <= AX_X;
            cur_neg_q <= 1'b0;
            cnt_q     <= '0;
            sh_bcd_q  <= '0;
            sh_neg_q  <= '0;
            out_bcd_q <= '0;
            out_neg_q <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (set_ovr_d) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr_i) begin
                ovr_q <= 1'b0;
            end

            if (sample_valid_i && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
                pend_q  <= 1'b1;
                px_q    <= data_x_i;
                py_q    <= data_y_i;
                pz_q    <= data_z_i;
                pmask_q <= axis_mask_i;
            end else if (state_q == ST_DONE) begin
                pend_q <= 1'b0;
            end

            if (state_q == ST_DONE) begin
                out_bcd_q <= sh_bcd_q;
                out_neg_q <= sh_neg_q;
            end

            if (job_go_d) begin
                wx_q     <= job_x_d;
                wy_q     <= job_y_d;
                wz_q     <= job_z_d;
                wmask_q  <= job_mask_d;
                sh_bcd_q <= '0;
                sh_neg_q <= '0;
                if (job_first_d == AX_NONE) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_LOAD;
                    ax_q    <= job_first_d;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        cur_neg_q <= sel_neg_d;
                        cnt_q     <= CNT_W'(DATA_W - 1);
                        state_q   <= ST_CONV;
                    end
                    ST_CONV: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_STORE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_STORE: begin
                        if (dab_valid) begin
                            sh_bcd_q[ax_q] <= dab_bcd;
                            sh_neg_q[ax_q] <= cur_neg_q;
                        end
                        if (next_ax_d == AX_NONE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                            ax_q    <= next_ax_d;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign overrun_o = ovr_q;
    assign bcd_x_o   = out_bcd_q[AX_X];
    assign bcd_y_o   = out_bcd_q[AX_Y];
    assign bcd_z_o   = out_bcd_q[AX_Z];
    assign neg_x_o   = out_neg_q[AX_X];
    assign neg_y_o   = out_neg_q[AX_Y];
    assign neg_z_o   = out_neg_q[AX_Z];

endmodule
